// File: rtl/fifo_drain_sched_pkg.sv
// Shared constants for the varint/raw FIFO drain scheduler: state encoding,
// beat kinds and default bus widths.
package fifo_drain_sched_pkg;

  localparam int DW_DEF = 32;
  localparam int IW_DEF = 10;
  localparam int SW_DEF = 4;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_ADV  = 2'd2;

  localparam logic KIND_VARINT = 1'b0;
  localparam logic KIND_RAW    = 1'b1;

endpackage

// File: rtl/fifo_drain_sched_perf.sv
// Wrapping 32-bit event counters for the drain scheduler; built only when
// FIFO_DRAIN_SCHED_PERF_EN is defined.
module fifo_drain_sched_perf
  import fifo_drain_sched_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        sync_clr,
  input  logic        out_valid,
  input  logic        out_ready,
  input  logic        out_kind,
  input  logic        rec_done,
  output logic [31:0] perf_v_beats,
  output logic [31:0] perf_r_beats,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_recs
);

  logic [31:0] v_beats_q, r_beats_q, stall_q, recs_q;
  logic        accept;

  // A beat presented while a clear is asserted is dropped, so it is not counted.
  assign accept = out_valid && out_ready && !sync_clr;

  always_ff @(posedge clk) begin
    if (reset || sync_clr) begin
      v_beats_q <= '0;
      r_beats_q <= '0;
      stall_q   <= '0;
      recs_q    <= '0;
    end else begin
      if (accept && out_kind == KIND_VARINT) v_beats_q <= v_beats_q + 32'd1;
      if (accept && out_kind == KIND_RAW)    r_beats_q <= r_beats_q + 32'd1;
      if (out_valid && !out_ready)           stall_q   <= stall_q + 32'd1;
      if (rec_done)                          recs_q    <= recs_q + 32'd1;
    end
  end

  assign perf_v_beats = v_beats_q;
  assign perf_r_beats = r_beats_q;
  assign perf_stall   = stall_q;
  assign perf_recs    = recs_q;

endmodule

// File: rtl/fifo_drain_sched.sv
// Serializes varint and raw FIFO heads into one encoder stream in record order.
// Optional perf counters under FIFO_DRAIN_SCHED_PERF_EN.
module fifo_drain_sched
  import fifo_drain_sched_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int IW = IW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sync_clr,
  input  logic          v_empty,
  input  logic [DW-1:0] v_data,
  input  logic [IW-1:0] v_index,
  output logic          v_pop,
  input  logic          r_empty,
  input  logic [DW-1:0] r_data,
  input  logic [IW-1:0] r_index,
  input  logic [SW-1:0] r_wstrb,
  output logic          r_pop,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [SW-1:0] out_wstrb,
  output logic          out_kind,
  output logic [IW-1:0] out_index,
  output logic          rec_done,
  output logic [IW-1:0] rec_index,
  output logic [IW-1:0] cur_index
`ifdef FIFO_DRAIN_SCHED_PERF_EN
  ,
  output logic [31:0]   perf_v_beats,
  output logic [31:0]   perf_r_beats,
  output logic [31:0]   perf_stall,
  output logic [31:0]   perf_recs
`endif
);

  logic          clr;
  logic [1:0]    state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic          kind_q, kind_d;
  logic [IW-1:0] index_q, index_d;
  logic [IW-1:0] cur_q, cur_d;
  logic          vm, rm, rec_complete, sel_en, load_v, load_r;

  assign clr = reset || sync_clr;

  always_comb begin
    vm           = !v_empty && (v_index == cur_q);
    rm           = !r_empty && (r_index == cur_q);
    // Upstream indices only increase, so a later head means the record is closed.
    rec_complete = !vm && !rm && (!v_empty || !r_empty);
    sel_en       = (state_q == ST_RUN) || (state_q == ST_HOLD && out_ready);
    load_v       = sel_en && vm && !clr;
    load_r       = sel_en && !vm && rm && !clr;

    state_d = state_q;
    data_d  = data_q;
    wstrb_d = wstrb_q;
    kind_d  = kind_q;
    index_d = index_q;
    cur_d   = cur_q;

    if (load_v) begin
      data_d  = v_data;
      wstrb_d = '1;
      kind_d  = KIND_VARINT;
      index_d = v_index;
    end else if (load_r) begin
      data_d  = r_data;
      wstrb_d = r_wstrb;
      kind_d  = KIND_RAW;
      index_d = r_index;
    end

    case (state_q)
      ST_RUN, ST_HOLD: begin
        if (sel_en) begin
          if (load_v || load_r) state_d = ST_HOLD;
          else if (rec_complete) state_d = ST_ADV;
          else                   state_d = ST_RUN;
        end
      end
      ST_ADV: begin
        state_d = ST_RUN;
        cur_d   = cur_q + IW'(1);
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_RUN;
      data_q  <= '0;
      wstrb_q <= '0;
      kind_q  <= 1'b0;
      index_q <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      wstrb_q <= wstrb_d;
      kind_q  <= kind_d;
      index_q <= index_d;
      cur_q   <= cur_d;
    end
  end

  assign v_pop     = load_v;
  assign r_pop     = load_r;
  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = data_q;
  assign out_wstrb = wstrb_q;
  assign out_kind  = kind_q;
  assign out_index = index_q;
  assign rec_done  = (state_q == ST_ADV);
  assign rec_index = rec_done ? cur_q : '0;
  assign cur_index = cur_q;

`ifdef FIFO_DRAIN_SCHED_PERF_EN
  fifo_drain_sched_perf u_perf (
    .clk          (clk),
    .reset        (reset),
    .sync_clr     (sync_clr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_kind     (out_kind),
    .rec_done     (rec_done),
    .perf_v_beats (perf_v_beats),
    .perf_r_beats (perf_r_beats),
    .perf_stall   (perf_stall),
    .perf_recs    (perf_recs)
  );
`endif

endmodule

// File: tb/tb_fifo_drain_sched.sv
// Directed bench for fifo_drain_sched: queue-modelled show-ahead FIFOs and an
// event scoreboard of expected beats and record completions.
module tb_fifo_drain_sched;
  import fifo_drain_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset, sync_clr;
  logic        v_empty, r_empty, v_pop, r_pop;
  logic [31:0] v_data, r_data, out_data;
  logic [9:0]  v_index, r_index, out_index, rec_index, cur_index;
  logic [3:0]  r_wstrb, out_wstrb;
  logic        out_valid, out_ready, out_kind, rec_done;
`ifdef FIFO_DRAIN_SCHED_PERF_EN
  logic [31:0] perf_v_beats, perf_r_beats, perf_stall, perf_recs;
`endif

  always #5 clk = ~clk;

  fifo_drain_sched dut (
    .clk(clk), .reset(reset), .sync_clr(sync_clr),
    .v_empty(v_empty), .v_data(v_data), .v_index(v_index), .v_pop(v_pop),
    .r_empty(r_empty), .r_data(r_data), .r_index(r_index), .r_wstrb(r_wstrb), .r_pop(r_pop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_wstrb(out_wstrb), .out_kind(out_kind), .out_index(out_index),
    .rec_done(rec_done), .rec_index(rec_index), .cur_index(cur_index)
`ifdef FIFO_DRAIN_SCHED_PERF_EN
    , .perf_v_beats(perf_v_beats), .perf_r_beats(perf_r_beats),
    .perf_stall(perf_stall), .perf_recs(perf_recs)
`endif
  );

  typedef struct packed {logic [31:0] d; logic [9:0] idx; logic [3:0] s;} ent_t;
  typedef struct packed {logic evt; logic [31:0] d; logic [3:0] s; logic k; logic [9:0] idx;} ev_t;

  ent_t vq[$];
  ent_t rq[$];
  ev_t  expq[$];
  int   total = 0;
  int   bad = 0;
  logic last_pv, last_pr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    v_empty = (vq.size() == 0);
    v_data  = v_empty ? 32'h0 : vq[0].d;
    v_index = v_empty ? 10'h0 : vq[0].idx;
    r_empty = (rq.size() == 0);
    r_data  = r_empty ? 32'h0 : rq[0].d;
    r_index = r_empty ? 10'h0 : rq[0].idx;
    r_wstrb = r_empty ? 4'h0 : rq[0].s;
  endtask

  task automatic push_v(input logic [31:0] d, input logic [9:0] idx);
    vq.push_back('{d: d, idx: idx, s: 4'h0});
    refresh();
  endtask

  task automatic push_r(input logic [31:0] d, input logic [9:0] idx, input logic [3:0] s);
    rq.push_back('{d: d, idx: idx, s: s});
    refresh();
  endtask

  task automatic exp_beat(input logic [31:0] d, input logic [3:0] s, input logic k, input logic [9:0] idx);
    expq.push_back('{evt: 1'b0, d: d, s: s, k: k, idx: idx});
  endtask

  task automatic exp_rec(input logic [9:0] idx);
    expq.push_back('{evt: 1'b1, d: 32'h0, s: 4'h0, k: 1'b0, idx: idx});
  endtask

  // One clock: sample decisions before the edge, then advance FIFOs and score.
  task automatic step();
    logic pv, pr, ve, re, acc, rd;
    ev_t  obs, e;
    #1;
    pv  = v_pop;  pr = r_pop;  ve = v_empty;  re = r_empty;
    acc = out_valid && out_ready && !sync_clr && !reset;
    rd  = rec_done && !sync_clr && !reset;
    obs = acc ? '{evt: 1'b0, d: out_data, s: out_wstrb, k: out_kind, idx: out_index}
              : '{evt: 1'b1, d: 32'h0, s: 4'h0, k: 1'b0, idx: rec_index};
    if (pv || pr) chk("single_pop", {pv, pr} == 2'b11, 1'b0);
    if (pv) chk("v_pop_nonempty", ve, 1'b0);
    if (pr) chk("r_pop_nonempty", re, 1'b0);
    if (rd) chk("rec_done_no_pop", {pv, pr}, 2'b00);
    @(posedge clk);
    #1;
    if (pv) void'(vq.pop_front());
    if (pr) void'(rq.pop_front());
    refresh();
    last_pv = pv;
    last_pr = pr;
    if (acc || rd) begin
      chk("event_expected", expq.size() != 0, 1'b1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk(rd ? "rec_done_event" : "beat_event", obs, e);
      end
    end
    #1;
  endtask

  task automatic drain(input string tag, input int budget, output int n);
    n = 0;
    while (expq.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, expq.size(), 0);
    expq.delete();
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, out_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; sync_clr = 1'b0; out_ready = 1'b0;
    last_pv = 1'b0; last_pr = 1'b0;
    refresh();
    #2;
    step(); step();
    reset = 1'b0;
    #1;
    // Reset state
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_pops", {v_pop, r_pop}, 2'b00);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_wstrb", out_wstrb, 4'h0);
    chk("rst_out_kind_index", {out_kind, out_index}, 11'h0);
    chk("rst_rec", {rec_done, rec_index}, 11'h0);
    chk("rst_cur_index", cur_index, 10'h0);
    chk("rst_state", dut.state_q, ST_RUN);
`ifdef FIFO_DRAIN_SCHED_PERF_EN
    chk("rst_perf", {perf_v_beats, perf_r_beats}, 64'h0);
    chk("rst_perf2", {perf_stall, perf_recs}, 64'h0);
`endif

    // Varint before raw, record boundary, back-to-back beats
    push_v(32'hA, 10'd0); push_v(32'hB, 10'd0); push_v(32'hD, 10'd1);
    push_r(32'hC, 10'd0, 4'h3);
    exp_beat(32'hA, 4'hF, KIND_VARINT, 10'd0);
    exp_beat(32'hB, 4'hF, KIND_VARINT, 10'd0);
    exp_beat(32'hC, 4'h3, KIND_RAW, 10'd0);
    exp_rec(10'd0);
    exp_beat(32'hD, 4'hF, KIND_VARINT, 10'd1);
    out_ready = 1'b1;
    drain("order", 40, n);
    chk("order_cycles", n, 7);
    chk("order_cur_index", cur_index, 10'd1);

    // Back-pressure holds the beat
    out_ready = 1'b0;
    push_v(32'h11, 10'd1);
    exp_beat(32'h11, 4'hF, KIND_VARINT, 10'd1);
    wait_valid("bp", 10);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_data", out_data, 32'h11);
      chk("bp_hold", {out_valid, last_pv, last_pr}, 3'b100);
    end
`ifdef FIFO_DRAIN_SCHED_PERF_EN
    chk("bp_perf_stall", perf_stall, 32'd5);
`endif
    out_ready = 1'b1;
    drain("bp", 10, n);
`ifdef FIFO_DRAIN_SCHED_PERF_EN
    chk("perf_v_beats", perf_v_beats, 32'd4);
    chk("perf_r_beats", perf_r_beats, 32'd1);
    chk("perf_recs", perf_recs, 32'd1);
`endif

    // Partial record: no completion until a later index shows up
    push_v(32'h1, 10'd1);
    exp_beat(32'h1, 4'hF, KIND_VARINT, 10'd1);
    drain("partial", 10, n);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("partial_no_rec_done", {rec_done, out_valid}, 2'b00);
      chk("partial_cur_index", cur_index, 10'd1);
    end
    push_r(32'h22, 10'd2, 4'hF);
    exp_rec(10'd1);
    exp_beat(32'h22, 4'hF, KIND_RAW, 10'd2);
    drain("partial_close", 10, n);

    // Walk indices up to 1023 and wrap to 0
    push_v(32'h33, 10'd1023);
    push_v(32'h44, 10'd0);
    for (int i = 2; i < 1023; i++) exp_rec(10'(i));
    exp_beat(32'h33, 4'hF, KIND_VARINT, 10'd1023);
    exp_rec(10'd1023);
    exp_beat(32'h44, 4'hF, KIND_VARINT, 10'd0);
    drain("wrap", 4000, n);
    chk("wrap_cur_index", cur_index, 10'd0);
    chk("wrap_head_drained", v_empty, 1'b1);

    // Clear while a beat is held and accepted
    out_ready = 1'b0;
    push_v(32'h55, 10'd0);
    push_v(32'h66, 10'd0);
    wait_valid("clr", 10);
    sync_clr = 1'b1;
    out_ready = 1'b1;
    step();
    chk("clr_no_pop", {last_pv, last_pr}, 2'b00);
    chk("clr_out_valid", out_valid, 1'b0);
    chk("clr_cur_index", cur_index, 10'd0);
    chk("clr_out_data", out_data, 32'h0);
`ifdef FIFO_DRAIN_SCHED_PERF_EN
    chk("clr_perf", {perf_v_beats, perf_recs}, 64'h0);
`endif
    sync_clr = 1'b0;
    exp_beat(32'h66, 4'hF, KIND_VARINT, 10'd0);
    drain("clr_resume", 10, n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
